// File: rtl/vec_magnitude.sv
// rtl/vec_magnitude.sv - integer square root of x*x+y*y or x*y, one root bit per cycle
module vec_magnitude #(
    parameter int W     = 8,
    parameter int ROUND = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   mag,
    output logic [W+1:0] rem,
    output logic         busy
);

    localparam int R  = W + 1;
    localparam int CW = $clog2(R);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Radicand, left-aligned: its top two bits are consumed each CALC edge.
    logic [2*R-1:0] s_reg;
    logic [R-1:0]   root_reg;
    logic [W+1:0]   prem;
    logic [CW-1:0]  cnt;

    logic [2*W-1:0] xx;
    logic [2*W-1:0] yy;
    logic [2*W-1:0] xy;
    logic [2*W:0]   s_calc;

    logic [W+3:0]   shifted;
    logic [W+3:0]   trial;
    logic [W+3:0]   diff;
    logic           ge;
    logic [R-1:0]   next_root;
    logic [W+1:0]   next_rem;
    logic           round_up;
    logic [W:0]     mag_nxt;

    logic           accept;
    logic           last_step;

    assign accept    = (state == IDLE) && in_valid;
    assign last_step = (state == CALC) && (cnt == '0);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Operand product/sum of squares, widened so nothing can overflow.
    always_comb begin
        xx     = {{W{1'b0}}, x} * {{W{1'b0}}, x};
        yy     = {{W{1'b0}}, y} * {{W{1'b0}}, y};
        xy     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        s_calc = mode ? {1'b0, xy} : ({1'b0, xx} + {1'b0, yy});
    end

    // One restoring square-root step plus the rounding decision on the result it yields.
    always_comb begin
        shifted   = {prem, s_reg[2*R-1 -: 2]};
        trial     = {1'b0, root_reg, 2'b01};
        diff      = shifted - trial;
        ge        = (shifted >= trial);
        next_root = {root_reg[R-2:0], ge};
        next_rem  = ge ? diff[W+1:0] : shifted[W+1:0];
        round_up  = (ROUND != 0) && (next_rem > {1'b0, next_root});
        mag_nxt   = round_up ? (next_root + R'(1)) : next_root;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, R steps in CALC, hold in DONE until taken.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: load radicand on accept, iterate in CALC, publish results entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_reg    <= '0;
            root_reg <= '0;
            prem     <= '0;
            cnt      <= '0;
            mag      <= '0;
            rem      <= '0;
        end else if (accept) begin
            s_reg    <= {1'b0, s_calc};
            root_reg <= '0;
            prem     <= '0;
            cnt      <= CW'(R - 1);
        end else if (state == CALC) begin
            s_reg    <= {s_reg[2*R-3:0], 2'b00};
            root_reg <= next_root;
            prem     <= next_rem;
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
            if (last_step) begin
                mag <= mag_nxt;
                rem <= next_rem;
            end
        end
    end

endmodule

// File: tb/tb_vec_magnitude.sv
// tb/tb_vec_magnitude.sv - directed and model-checked bench for vec_magnitude
module tb_vec_magnitude;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] x;
    logic [7:0] y;
    logic       mode;
    logic       out_ready;

    logic       in_ready0, out_valid0, busy0;
    logic [8:0] mag0;
    logic [9:0] rem0;
    logic       in_ready1, out_valid1, busy1;
    logic [8:0] mag1;
    logic [9:0] rem1;

    int checks;
    int failures;

    vec_magnitude #(.W(8), .ROUND(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .x(x), .y(y), .mode(mode), .out_valid(out_valid0), .out_ready(out_ready),
        .mag(mag0), .rem(rem0), .busy(busy0)
    );

    vec_magnitude #(.W(8), .ROUND(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .x(x), .y(y), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready),
        .mag(mag1), .rem(rem1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int isqrt(input int s);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    // Accept one operand set, check latency/flags during CALC, check results, consume them.
    task automatic run_op(input string tag, input int xi, input int yi, input logic mi,
                          input int e_mag0, input int e_mag1, input int e_rem);
        int  n;
        bool_t_dummy: begin end
        x        = 8'(xi);
        y        = 8'(yi);
        mode     = mi;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        x        = 8'hA5;
        y        = 8'h5A;
        mode     = ~mi;
        n        = 0;
        begin
            int flag_bad;
            flag_bad = 0;
            for (int i = 0; i < 30; i++) begin
                if (in_ready0 !== 1'b0 || busy0 !== 1'b1 || in_ready1 !== 1'b0 || busy1 !== 1'b1)
                    flag_bad = 1;
                if (out_valid0 === 1'b1) break;
                tick();
                n++;
            end
            chk({tag, "_flags_in_calc"}, flag_bad, 0);
        end
        chk({tag, "_latency"}, n, 9);
        chk({tag, "_valid_r1"}, int'(out_valid1), 1);
        chk({tag, "_mag_r0"}, int'(mag0), e_mag0);
        chk({tag, "_rem_r0"}, int'(rem0), e_rem);
        chk({tag, "_mag_r1"}, int'(mag1), e_mag1);
        chk({tag, "_rem_r1"}, int'(rem1), e_rem);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, int'(out_valid0), 0);
        chk({tag, "_ready_back"}, int'(in_ready0), 1);
    endtask

    initial begin
        int s, r, rm, m1, xi, yi;
        logic mi;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", int'(in_ready0), 1);
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_busy", int'(busy0), 0);
        chk("rst_mag", int'(mag0), 0);
        chk("rst_rem", int'(rem0), 0);
        rst = 1'b0;

        // out_ready while idle does nothing
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        chk("idle_out_ready_valid", int'(out_valid0), 0);
        chk("idle_out_ready_ready", int'(in_ready0), 1);

        run_op("x3y4", 3, 4, 1'b0, 5, 5, 0);
        run_op("x255y255", 255, 255, 1'b0, 360, 361, 450);
        run_op("m1x8y2", 8, 2, 1'b1, 4, 4, 0);
        run_op("m1x0y200", 0, 200, 1'b1, 0, 0, 0);
        run_op("x1y1", 1, 1, 1'b0, 1, 1, 1);

        // hold the result for 5 cycles with out_ready low
        x = 8'd5; y = 8'd12; mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("hold_valid_rise", int'(out_valid0), 1);
        begin
            int bad;
            bad = 0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 || mag0 !== 9'd13 || rem0 !== 10'd0)
                    bad = 1;
            end
            chk("hold_stable", bad, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("hold_release_valid", int'(out_valid0), 0);
        chk("hold_release_ready", int'(in_ready0), 1);
        run_op("after_hold", 9, 12, 1'b0, 15, 15, 0);

        // reset on the 4th CALC edge aborts the operation
        x = 8'd200; y = 8'd100; mode = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        chk("abort_in_ready", int'(in_ready0), 1);
        chk("abort_busy", int'(busy0), 0);
        chk("abort_out_valid", int'(out_valid0), 0);
        chk("abort_mag", int'(mag0), 0);
        chk("abort_rem", int'(rem0), 0);
        rst = 1'b0;
        run_op("x6y8", 6, 8, 1'b0, 10, 10, 0);

        // model-checked sweep
        for (int k = 0; k < 16; k++) begin
            xi = int'($urandom_range(0, 255));
            yi = int'($urandom_range(0, 255));
            mi = 1'($urandom_range(0, 1));
            s  = mi ? xi * yi : xi * xi + yi * yi;
            r  = isqrt(s);
            rm = s - r * r;
            m1 = (rm > r) ? r + 1 : r;
            run_op($sformatf("rnd%0d", k), xi, yi, mi, r, m1, rm);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
